// File: rtl/fp16_mult_pipe.sv
// Pipelined binary16 multiplier: RNE rounding, subnormal flush-to-zero, overflow to infinity.
// Latency 3 cycles after the sampling edge, one pair per cycle; no backpressure (consumer must take result on valid_out).
module fp16_mult_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        valid_out,
  output logic [15:0] result
);

  // Stage 1: unpack and classify
  logic        r_v1, r_s1, r_zero1, r_inf1, r_nan1;
  logic [4:0]  r_ea1, r_eb1;
  logic [10:0] r_ma1, r_mb1;

  logic [4:0]  w_ea, w_eb;
  logic [9:0]  w_fa, w_fb;
  assign w_ea = a[14:10];
  assign w_eb = b[14:10];
  assign w_fa = a[9:0];
  assign w_fb = b[9:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_s1    <= 1'b0;
      r_zero1 <= 1'b0;
      r_inf1  <= 1'b0;
      r_nan1  <= 1'b0;
      r_ea1   <= 5'd0;
      r_eb1   <= 5'd0;
      r_ma1   <= 11'd0;
      r_mb1   <= 11'd0;
    end else begin
      r_v1 <= valid_in;
      if (valid_in) begin
        r_s1    <= a[15] ^ b[15];
        r_ea1   <= w_ea;
        r_eb1   <= w_eb;
        r_ma1   <= (w_ea == 5'd0) ? 11'd0 : {1'b1, w_fa};
        r_mb1   <= (w_eb == 5'd0) ? 11'd0 : {1'b1, w_fb};
        r_zero1 <= (w_ea == 5'd0) || (w_eb == 5'd0);
        r_inf1  <= ((w_ea == 5'h1F) && (w_fa == 10'd0)) || ((w_eb == 5'h1F) && (w_fb == 10'd0));
        r_nan1  <= ((w_ea == 5'h1F) && (w_fa != 10'd0)) || ((w_eb == 5'h1F) && (w_fb != 10'd0));
      end
    end
  end

  // Stage 2: significand product and unbiased exponent sum
  logic               r_v2, r_s2, r_zero2, r_inf2, r_nan2;
  logic [21:0]        r_p2;
  logic signed [6:0]  r_e2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2    <= 1'b0;
      r_s2    <= 1'b0;
      r_zero2 <= 1'b0;
      r_inf2  <= 1'b0;
      r_nan2  <= 1'b0;
      r_p2    <= 22'd0;
      r_e2    <= 7'sd0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_s2    <= r_s1;
        r_zero2 <= r_zero1;
        r_inf2  <= r_inf1;
        r_nan2  <= r_nan1;
        r_p2    <= r_ma1 * r_mb1;
        r_e2    <= $signed({2'b00, r_ea1}) + $signed({2'b00, r_eb1}) - 7'sd15;
      end
    end
  end

  // Stage 3: normalize and round to nearest-even
  logic              w_hi, w_guard, w_sticky, w_rnd, w_carry;
  logic [9:0]        w_frac;
  logic [10:0]       w_frac_sum;
  logic signed [6:0] w_exp;

  always_comb begin
    w_hi = r_p2[21];
    if (w_hi) begin
      w_frac   = r_p2[20:11];
      w_guard  = r_p2[10];
      w_sticky = |r_p2[9:0];
    end else begin
      w_frac   = r_p2[19:10];
      w_guard  = r_p2[9];
      w_sticky = |r_p2[8:0];
    end
    w_rnd      = w_guard & (w_sticky | w_frac[0]);
    w_frac_sum = {1'b0, w_frac} + {10'd0, w_rnd};
    w_carry    = w_frac_sum[10];
    w_exp      = r_e2 + $signed({6'd0, w_hi}) + $signed({6'd0, w_carry});
  end

  logic              r_v3, r_s3, r_zero3, r_inf3, r_nan3;
  logic [9:0]        r_f3;
  logic signed [6:0] r_e3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v3    <= 1'b0;
      r_s3    <= 1'b0;
      r_zero3 <= 1'b0;
      r_inf3  <= 1'b0;
      r_nan3  <= 1'b0;
      r_f3    <= 10'd0;
      r_e3    <= 7'sd0;
    end else begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_s3    <= r_s2;
        r_zero3 <= r_zero2;
        r_inf3  <= r_inf2;
        r_nan3  <= r_nan2;
        r_f3    <= w_frac_sum[9:0];
        r_e3    <= w_exp;
      end
    end
  end

  // Special-case priority and pack; result only moves with valid_out
  logic [15:0] w_res;

  always_comb begin
    w_res = {r_s3, r_e3[4:0], r_f3};
    if (r_nan3 || (r_inf3 && r_zero3)) begin
      w_res = 16'h7E00;
    end else if (r_inf3) begin
      w_res = {r_s3, 5'h1F, 10'h000};
    end else if (r_zero3) begin
      w_res = {r_s3, 15'h0000};
    end else if (r_e3 >= 7'sd31) begin
      w_res = {r_s3, 5'h1F, 10'h000};
    end else if (r_e3 <= 7'sd0) begin
      w_res = {r_s3, 15'h0000};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      result    <= 16'h0000;
    end else begin
      valid_out <= r_v3;
      if (r_v3) begin
        result <= w_res;
      end
    end
  end

endmodule

// File: tb/tb_fp16_mult_pipe.sv
// Scoreboard bench for fp16_mult_pipe: expected products queued at issue, compared when due.
module tb_fp16_mult_pipe;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [15:0] a;
  logic [15:0] b;
  logic        valid_out;
  logic [15:0] result;

  fp16_mult_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .a         (a),
    .b         (b),
    .valid_out (valid_out),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] val;
  } exp_t;

  exp_t        exp_q[$];
  int          t;
  logic [15:0] last;
  int          n_cmp;
  int          n_err;

  localparam int NV = 13;
  logic [15:0] va [NV] = '{16'h3C00, 16'h3E00, 16'hC000, 16'h3C01, 16'h4000, 16'h3FFF, 16'h7C00,
                           16'h7E55, 16'hFC00, 16'h8000, 16'h7BFF, 16'h0400, 16'h0001};
  logic [15:0] vb [NV] = '{16'h4000, 16'h3E00, 16'h4200, 16'h3C01, 16'h4000, 16'h3FFF, 16'h0000,
                           16'h3C00, 16'h4000, 16'h3C00, 16'h4000, 16'h3800, 16'h7BFF};
  logic [15:0] ve [NV] = '{16'h4000, 16'h4080, 16'hC600, 16'h3C02, 16'h4400, 16'h43FE, 16'h7E00,
                           16'h7E00, 16'hFC00, 16'h8000, 16'h7C00, 16'h0000, 16'h0000};

  task automatic test_reset;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    a        = 16'h3C00;
    b        = 16'h3C00;
    last     = 16'h0000;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (valid_out !== 1'b0) begin
      n_err++; $display("FAIL reset_valid_out got %b want 0", valid_out);
    end
    n_cmp++;
    if (result !== 16'h0000) begin
      n_err++; $display("FAIL reset_result got %h want 0000", result);
    end
    rst_n = 1'b1;
  endtask

  // One operand pair every other cycle, random operands on the idle cycles.
  task automatic test_products;
    int idx;
    idx = 0;
    for (int c = 0; c < 2 * NV + 12; c++) begin
      @(negedge clk); t++;
      if (exp_q.size() > 0 && exp_q[0].due == t) begin
        n_cmp++;
        if (valid_out !== 1'b1) begin
          n_err++; $display("FAIL products_valid t=%0d got %b want 1", t, valid_out);
        end
        n_cmp++;
        if (result !== exp_q[0].val) begin
          n_err++; $display("FAIL products_result t=%0d got %h want %h", t, result, exp_q[0].val);
        end
        last = exp_q[0].val;
        void'(exp_q.pop_front());
      end else begin
        n_cmp++;
        if (valid_out !== 1'b0) begin
          n_err++; $display("FAIL products_idle_valid t=%0d got %b want 0", t, valid_out);
        end
        n_cmp++;
        if (result !== last) begin
          n_err++; $display("FAIL products_hold t=%0d got %h want %h", t, result, last);
        end
      end
      if ((c % 2 == 0) && idx < NV) begin
        valid_in = 1'b1; a = va[idx]; b = vb[idx];
        exp_q.push_back('{due: t + 4, val: ve[idx]});
        idx++;
      end else begin
        valid_in = 1'b0; a = 16'($urandom); b = 16'($urandom);
      end
      if (idx >= NV && exp_q.size() == 0) break;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL products_timeout pending %0d want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  // Five back-to-back pairs, two idle cycles, one more pair.
  task automatic test_back_to_back;
    int sel [8] = '{0, 1, 2, 4, 5, -1, -1, 10};
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); t++;
      if (exp_q.size() > 0 && exp_q[0].due == t) begin
        n_cmp++;
        if (valid_out !== 1'b1) begin
          n_err++; $display("FAIL stream_valid t=%0d got %b want 1", t, valid_out);
        end
        n_cmp++;
        if (result !== exp_q[0].val) begin
          n_err++; $display("FAIL stream_result t=%0d got %h want %h", t, result, exp_q[0].val);
        end
        last = exp_q[0].val;
        void'(exp_q.pop_front());
      end else begin
        n_cmp++;
        if (valid_out !== 1'b0) begin
          n_err++; $display("FAIL stream_gap_valid t=%0d got %b want 0", t, valid_out);
        end
        n_cmp++;
        if (result !== last) begin
          n_err++; $display("FAIL stream_hold t=%0d got %h want %h", t, result, last);
        end
      end
      if (c < 8 && sel[c] >= 0) begin
        valid_in = 1'b1; a = va[sel[c]]; b = vb[sel[c]];
        exp_q.push_back('{due: t + 4, val: ve[sel[c]]});
      end else begin
        valid_in = 1'b0; a = 16'($urandom); b = 16'($urandom);
      end
      if (c >= 8 && exp_q.size() == 0) break;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL stream_timeout pending %0d want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  // Two pairs in flight are killed by a one-cycle reset; a pair issued right as reset releases survives.
  task automatic test_reset_midflight;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk); t++;
      if (exp_q.size() > 0 && exp_q[0].due == t) begin
        n_cmp++;
        if (valid_out !== 1'b1) begin
          n_err++; $display("FAIL midrst_valid t=%0d got %b want 1", t, valid_out);
        end
        n_cmp++;
        if (result !== exp_q[0].val) begin
          n_err++; $display("FAIL midrst_result t=%0d got %h want %h", t, result, exp_q[0].val);
        end
        last = exp_q[0].val;
        void'(exp_q.pop_front());
      end else begin
        n_cmp++;
        if (valid_out !== 1'b0) begin
          n_err++; $display("FAIL midrst_idle_valid t=%0d got %b want 0", t, valid_out);
        end
        n_cmp++;
        if (result !== last) begin
          n_err++; $display("FAIL midrst_hold t=%0d got %h want %h", t, result, last);
        end
      end
      if (c < 2) begin
        valid_in = 1'b1; a = va[2 + c]; b = vb[2 + c];
      end else if (c == 2) begin
        valid_in = 1'b0;
        rst_n    = 1'b0;
        last     = 16'h0000;
        #1;
        n_cmp++;
        if (valid_out !== 1'b0 || result !== 16'h0000) begin
          n_err++; $display("FAIL midrst_async got %b/%h want 0/0000", valid_out, result);
        end
      end else if (c == 3) begin
        rst_n    = 1'b1;
        valid_in = 1'b1; a = va[5]; b = vb[5];
        exp_q.push_back('{due: t + 4, val: ve[5]});
      end else begin
        valid_in = 1'b0; a = 16'($urandom); b = 16'($urandom);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL midrst_timeout pending %0d want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin
    t     = 0;
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_products();
    test_back_to_back();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
